// File: rtl/mcp3002_channel_scheduler.sv
// Shares one MCP3002 between CH0/CH1: collects requests and periodic ticks, arbitrates
// round-robin, runs one 16-clock SPI frame per grant and publishes a 10-bit result.
module mcp3002_channel_scheduler #(
    parameter int HALF_DIV      = 2,
    parameter int SAMPLE_PERIOD = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_auto_en,
    input  logic       i_adc_dout,
    output logic       o_adc_cs_n,
    output logic       o_adc_sclk,
    output logic       o_adc_din,
    output logic       o_busy,
    output logic [1:0] o_grant,
    output logic [9:0] o_data0,
    output logic [9:0] o_data1,
    output logic [1:0] o_valid,
    output logic [1:0] o_overrun
);
    localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int TW = $clog2(SAMPLE_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_DONE, S_GAP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_div;
    logic [4:0]    r_half;
    logic [TW-1:0] r_tick_cnt;
    logic [1:0]    r_pend, r_grant, r_overrun;
    logic          r_last;
    logic [9:0]    r_shift, r_data0, r_data1;

    logic          w_div_end, w_tick, w_rise;
    logic [1:0]    w_set, w_pick;
    logic [3:0]    w_period;

    assign w_div_end = (r_div == DW'(HALF_DIV - 1));
    assign w_tick    = i_auto_en && (r_tick_cnt == TW'(SAMPLE_PERIOD - 1));
    assign w_set     = i_req | {2{w_tick}};
    assign w_period  = r_half[4:1];
    // End of a low half: the edge that raises SCLK is also the DOUT sample point.
    assign w_rise    = (r_state == S_SHIFT) && !r_half[0] && w_div_end;

    assign o_grant   = r_grant;
    assign o_data0   = r_data0;
    assign o_data1   = r_data1;
    assign o_overrun = r_overrun;

    always_comb begin
        w_pick = 2'b00;
        if (r_state == S_IDLE) begin
            case (r_pend)
                2'b01:   w_pick = 2'b01;
                2'b10:   w_pick = 2'b10;
                2'b11:   w_pick = r_last ? 2'b01 : 2'b10;
                default: w_pick = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_pick != 2'b00) w_state_nxt = S_CS_SETUP;
            S_CS_SETUP: if (w_div_end) w_state_nxt = S_SHIFT;
            S_SHIFT:    if (w_div_end && r_half == 5'd31) w_state_nxt = S_CS_HOLD;
            S_CS_HOLD:  if (w_div_end) w_state_nxt = S_DONE;
            S_DONE:     w_state_nxt = S_GAP;
            S_GAP:      if (w_div_end) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_adc_cs_n = 1'b1;
        o_adc_sclk = 1'b0;
        o_adc_din  = 1'b0;
        o_busy     = 1'b0;
        o_valid    = 2'b00;
        case (r_state)
            S_CS_SETUP: begin
                o_adc_cs_n = 1'b0;
                o_adc_din  = 1'b1;
                o_busy     = 1'b1;
            end
            S_SHIFT: begin
                o_adc_cs_n = 1'b0;
                o_adc_sclk = r_half[0];
                o_busy     = 1'b1;
                // Command word: start, single-ended, channel select, MSB-first.
                case (w_period)
                    4'd0, 4'd1, 4'd3: o_adc_din = 1'b1;
                    4'd2:             o_adc_din = r_grant[1];
                    default:          o_adc_din = 1'b0;
                endcase
            end
            S_CS_HOLD: begin
                o_adc_cs_n = 1'b0;
                o_busy     = 1'b1;
            end
            S_DONE: begin
                o_busy  = 1'b1;
                o_valid = r_grant;
            end
            S_GAP: begin
                o_busy = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_half <= '0;
        end else begin
            if (r_state == S_IDLE || r_state == S_DONE || w_div_end) r_div <= '0;
            else r_div <= r_div + 1'b1;
            if (r_state != S_SHIFT) r_half <= '0;
            else if (w_div_end) r_half <= r_half + 1'b1;
        end
    end

    // Counter parks at zero while auto sampling is off, so re-enabling gives a full period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (!i_auto_en || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend    <= 2'b00;
            r_overrun <= 2'b00;
            r_grant   <= 2'b00;
            r_last    <= 1'b1;
            r_shift   <= '0;
            r_data0   <= '0;
            r_data1   <= '0;
        end else begin
            // A set in the same cycle as the grant-clear wins.
            r_pend    <= (r_pend & ~w_pick) | w_set;
            r_overrun <= w_set & r_pend & ~w_pick;
            if (w_pick != 2'b00) begin
                r_grant <= w_pick;
                r_last  <= w_pick[1];
            end else if (r_state == S_GAP && w_div_end) begin
                r_grant <= 2'b00;
            end
            if (w_rise && w_period >= 4'd5 && w_period <= 4'd14) begin
                r_shift <= {r_shift[8:0], i_adc_dout};
            end
            if (r_state == S_CS_HOLD && w_div_end) begin
                if (r_grant[0]) r_data0 <= r_shift;
                if (r_grant[1]) r_data1 <= r_shift;
            end
        end
    end

endmodule
